// File: rtl/risc_imem.sv
// risc_imem: writable instruction memory for the RISC32 core.
//
// After reset an init sequencer writes FILL_WORD to every word, one word
// per cycle, and only then accepts fetches and loads. Fetches return
// through a registered read one cycle after acceptance. Init writes and
// loads share a single write port, which keeps the array mappable to
// a single-clock block RAM.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   fetch_req     fetch request (byte address on fetch_addr)
//   fetch_stall   holds the fetch output registers, blocks acceptance
//   fetch_ready   request accepted this cycle when fetch_req is high
//   fetch_valid   fetch_data / fetch_fault carry an accepted fetch
//   fetch_data    instruction word (0 on fault)
//   fetch_fault   accepted fetch was misaligned or out of range
//   load_en       write strobe (byte address load_addr, word load_data)
//   load_ready    load port accepts writes this cycle
//   load_err      one-cycle pulse: previous-cycle write was rejected
//   debug_state   FSM state (0 = INIT, 1 = RUN)
//
// Handshake: a fetch transfers on a rising edge where fetch_req and
// fetch_ready are both high; its result appears with fetch_valid on the
// next cycle. A load transfers on an edge where load_en and load_ready
// are both high. Requests presented while not ready are simply ignored,
// so the requester must keep them asserted until accepted.
module risc_imem #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_stall,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_fault,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_err,
    output logic                  debug_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [DEPTH_LOG2-1:0] init_cnt, init_cnt_next;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Word-aligned and no address bits above the array.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && ((addr >> (DEPTH_LOG2 + 2)) == '0);
    endfunction

    logic                  fetch_ok, load_ok;
    logic [DEPTH_LOG2-1:0] fetch_idx, load_idx;
    logic                  fetch_accept, load_accept;

    assign fetch_ok     = addr_ok(fetch_addr);
    assign load_ok      = addr_ok(load_addr);
    assign fetch_idx    = fetch_addr[DEPTH_LOG2+1:2];
    assign load_idx     = load_addr[DEPTH_LOG2+1:2];

    assign fetch_ready  = (state == RUN) && !fetch_stall;
    assign load_ready   = (state == RUN);
    assign fetch_accept = fetch_req && fetch_ready;
    assign load_accept  = load_en && load_ready;
    assign debug_state  = (state == RUN);

    // ---------------- init sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        case (state)
            INIT: begin
                init_cnt_next = init_cnt + 1'b1;
                // Last word written this cycle: the array is fully cleared.
                if (&init_cnt) state_next = RUN;
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // ---------------- single write port ----------------
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = init_cnt;
        wr_data = FILL_WORD;
        if (!reset) begin
            if (state == INIT) begin
                wr_en = 1'b1;
            end else if (load_accept && load_ok) begin
                wr_en   = 1'b1;
                wr_idx  = load_idx;
                wr_data = load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // ---------------- fetch output registers ----------------
    // The read samples the array before this edge's write lands, which
    // gives read-first behaviour for a same-cycle load to the same word.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            fetch_fault <= 1'b0;
        end else if (fetch_stall) begin
            fetch_valid <= fetch_valid;
            fetch_data  <= fetch_data;
            fetch_fault <= fetch_fault;
        end else if (fetch_accept) begin
            fetch_valid <= 1'b1;
            fetch_fault <= !fetch_ok;
            fetch_data  <= fetch_ok ? mem[fetch_idx] : '0;
        end else begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            fetch_fault <= 1'b0;
        end
    end

    // Rejected write: pulse regardless of fetch_stall.
    always_ff @(posedge clk) begin
        if (reset) load_err <= 1'b0;
        else       load_err <= load_accept && !load_ok;
    end

endmodule

// File: tb/tb_risc_imem.sv
// tb_risc_imem: directed bench for risc_imem with a 16-word array.
//
// A word-level model (array of words, init countdown, output expectations)
// advances on every rising edge and a compare process checks every DUT
// output against it on each falling edge. Directed steps add literal
// checks of the values worked out by hand.
module tb_risc_imem;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          DL   = 4;
    localparam int          NW   = 16;
    localparam logic [31:0] FILL = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_stall;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          fetch_fault;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          load_err;
    logic          debug_state;

    int n_cmp  = 0;
    int n_fail = 0;

    risc_imem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH_LOG2(DL),
        .FILL_WORD (FILL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_stall(fetch_stall),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_fault(fetch_fault),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_err   (load_err),
        .debug_state(debug_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [NW];
    bit          m_known = 0;
    bit          m_run   = 0;
    int          m_left  = 0;
    logic        m_valid = 0;
    logic        m_fault = 0;
    logic        m_lerr  = 0;
    logic [31:0] m_data  = 0;

    function automatic bit m_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a < NW * 4);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_known = 1;
            m_run   = 0;
            m_left  = NW;
            for (int i = 0; i < NW; i++) m_mem[i] = FILL;
            m_valid = 0;
            m_data  = 0;
            m_fault = 0;
            m_lerr  = 0;
        end else if (m_known) begin
            m_lerr = load_en && m_run && !m_ok(load_addr);
            if (!fetch_stall) begin
                if (fetch_req && m_run) begin
                    m_valid = 1;
                    m_fault = !m_ok(fetch_addr);
                    m_data  = m_fault ? 32'h0 : m_mem[fetch_addr / 4];
                end else begin
                    m_valid = 0;
                    m_data  = 0;
                    m_fault = 0;
                end
            end
            // Written after the read above: old word returned on a collision.
            if (load_en && m_run && m_ok(load_addr)) m_mem[load_addr / 4] = load_data;
            if (!m_run) begin
                m_left--;
                if (m_left == 0) m_run = 1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (m_known) begin
            check("cmp_fetch_ready", 32'(fetch_ready), 32'(m_run && !fetch_stall));
            check("cmp_load_ready",  32'(load_ready),  32'(m_run));
            check("cmp_state",       32'(debug_state), 32'(m_run));
            check("cmp_fetch_valid", 32'(fetch_valid), 32'(m_valid));
            check("cmp_fetch_fault", 32'(fetch_fault), 32'(m_fault));
            check("cmp_fetch_data",  fetch_data,       m_data);
            check("cmp_load_err",    32'(load_err),    32'(m_lerr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!fetch_ready && n < 100);
        check(name, n, 16);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req  = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset       = 1'b1;
        fetch_req   = 1'b0;
        fetch_addr  = '0;
        fetch_stall = 1'b0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;

        step();
        check("rst_fetch_ready", 32'(fetch_ready), 0);
        check("rst_fetch_valid", 32'(fetch_valid), 0);
        check("rst_load_ready",  32'(load_ready),  0);
        check("rst_state",       32'(debug_state), 0);
        reset = 1'b0;
        wait_ready("init_cycles");

        // Last word of the array reads back the fill value.
        do_fetch(32'h3C);
        check("fetch_3c_valid", 32'(fetch_valid), 1);
        check("fetch_3c_data",  fetch_data, 32'h0);
        check("fetch_3c_fault", 32'(fetch_fault), 0);

        do_load(32'h4, 32'hDEAD_BEEF);
        do_fetch(32'h4);
        check("fetch_4_data", fetch_data, 32'hDEAD_BEEF);

        // Back-to-back fetches.
        do_load(32'h0, 32'h1111_1111);
        fetch_req = 1'b1;
        fetch_addr = 32'h0; step();
        check("b2b_0", fetch_data, 32'h1111_1111);
        fetch_addr = 32'h4; step();
        check("b2b_4", fetch_data, 32'hDEAD_BEEF);
        fetch_addr = 32'h8; step();
        check("b2b_8", fetch_data, 32'h0);
        check("b2b_8_valid", 32'(fetch_valid), 1);
        fetch_req = 1'b0;

        // Faulting fetches.
        do_fetch(32'h6);
        check("mis_fault", 32'(fetch_fault), 1);
        check("mis_data", fetch_data, 32'h0);
        do_fetch(32'h400);
        check("range400_fault", 32'(fetch_fault), 1);
        do_fetch(32'h40);
        check("range40_fault", 32'(fetch_fault), 1);

        // Rejected loads: pulse for one cycle, array untouched.
        do_load(32'h400, 32'hBAD0_0001);
        check("lerr_400", 32'(load_err), 1);
        step();
        check("lerr_pulse_end", 32'(load_err), 0);
        do_load(32'h40, 32'hBAD0_0002);
        check("lerr_40", 32'(load_err), 1);
        do_fetch(32'h0);
        check("word0_kept", fetch_data, 32'h1111_1111);

        // Same-cycle load and fetch of one word: read-first.
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'h1234_5678;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        load_en = 1'b0; fetch_req = 1'b0;
        check("collide_old", fetch_data, 32'h0);
        do_fetch(32'h8);
        check("collide_new", fetch_data, 32'h1234_5678);

        // Stall holds the output; a bad load during stall still pulses once.
        do_fetch(32'h4);
        fetch_stall = 1'b1;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        load_en = 1'b1; load_addr = 32'h6; load_data = 32'h5555_5555;
        step();
        load_en = 1'b0;
        check("stall_ready", 32'(fetch_ready), 0);
        check("stall_data1", fetch_data, 32'hDEAD_BEEF);
        check("stall_lerr", 32'(load_err), 1);
        step();
        check("stall_data2", fetch_data, 32'hDEAD_BEEF);
        check("stall_lerr_end", 32'(load_err), 0);
        step();
        check("stall_valid3", 32'(fetch_valid), 1);
        check("stall_data3", fetch_data, 32'hDEAD_BEEF);
        fetch_stall = 1'b0;
        step();
        fetch_req = 1'b0;
        check("unstall_data", fetch_data, 32'h1111_1111);
        step();
        check("idle_valid", 32'(fetch_valid), 0);
        check("idle_data", fetch_data, 32'h0);

        // Reset in RUN with a fetch pending: dropped, array re-cleared.
        fetch_req = 1'b1; fetch_addr = 32'h4; reset = 1'b1;
        step();
        fetch_req = 1'b0; reset = 1'b0;
        check("run_rst_valid", 32'(fetch_valid), 0);
        wait_ready("reinit_cycles");
        fetch_req = 1'b1;
        for (int i = 0; i < NW; i++) begin
            fetch_addr = 32'(i * 4);
            step();
            check("readback_fill", fetch_data, FILL);
        end
        fetch_req = 1'b0;

        // Reset at init count 7 restarts the full sequence.
        reset = 1'b1; step(); reset = 1'b0;
        repeat (7) step();
        reset = 1'b1; step(); reset = 1'b0;
        wait_ready("midinit_cycles");
        do_fetch(32'h8);
        check("midinit_data", fetch_data, FILL);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
